sclic_irq_arbiter: RTL and testbench
====================================

# sclic_irq_arbiter

Parametrised CLIC-style interrupt arbiter for the CVA6 core when the Sclic extension is enabled. It holds per-source pending, enable, attribute and level state, and picks the highest-level eligible source. It offers that source to the core's CSR/controller with a valid/ready handshake and retracts it with a kill pulse if it becomes ineligible. It generalises the fixed single-line external interrupt into NrSrc independently configured sources with programmable trigger mode and level.

## Interface
- NrSrc, 64: number of interrupt sources (2..1024).
- LevelW, 8: width of per-source level/ctl field.
- SrcW, $clog2(NrSrc): derived source index width.
- clk_i in 1: core clock.
- rst_ni in 1: asynchronous active-low reset.
- irq_src_i in NrSrc: raw source lines, synchronous to clk_i.
- reg_req_i in 1: register access strobe.
- reg_we_i in 1: 1 = write, 0 = read.
- reg_addr_i in SrcW+2: {source index, field}; field 0 = ip, 1 = ie, 2 = attr, 3 = ctl.
- reg_wdata_i in 8: write data.
- reg_rdata_o out 8: read data.
- reg_rvalid_o out 1: read data valid.
- thresh_i in LevelW: effective threshold, max(mintthresh, current mil), supplied by the core.
- irq_valid_o out 1: interrupt offered.
- irq_id_o out SrcW: offered source.
- irq_level_o out LevelW: offered level.
- irq_shv_o out 1: selective hardware vectoring bit of the offered source.
- irq_ready_i in 1: core accepts the offer.
- irq_kill_o out 1: one-cycle retraction pulse.

## Operation
- Per source: ip (1b), ie (1b), attr = {shv, pol, trig} (3b), ctl (LevelW). Reset: all 0 (level, active-high, disabled).
- Active value = irq_src_i[k] ^ pol.
- Level-triggered (trig=0): ip follows the registered active value every cycle. SW writes to ip are ignored.
- Edge-triggered (trig=1): ip is set on a 0->1 transition of the active value, detected against a previous-value register. ip is cleared by a SW write of 0 or by the accept handshake for that id. When an edge and a clear occur in the same cycle, the edge wins.
- A source is eligible when ip & ie & (ctl > thresh_i). A level equal to the threshold is not eligible.
- Winner register, updated every cycle: highest ctl among eligible sources; on ties the lowest index wins; includes a found flag.
- FSM states:
  - IDLE -> OFFER when found; latch id, level and shv.
  - OFFER -> ACK on irq_ready_i. irq_ready_i is sampled only while irq_valid_o = 1.
  - OFFER -> KILL when the latched id becomes ineligible, e.g. ie cleared or thresh_i raised to >= its level. If ready and ineligibility occur in the same cycle, accept wins.
  - KILL -> IDLE after one cycle.
  - ACK -> IDLE after one cycle, which lets the ip clear reach the winner register.
- While in OFFER, a higher-level arrival does not replace the offer. It is re-arbitrated after ACK.
- Register read: reg_rdata_o is returned the cycle after reg_req_i, with reg_rvalid_o = 1 for one cycle. Unused bits read 0. Writes take effect at the end of the request cycle.
- Reset mid-operation: all state, including FSM state = IDLE, is cleared asynchronously. No kill pulse is emitted.

## Timing
- Every output resets to 0.
- Edge in cycle N -> ip = 1 in N+1 -> winner in N+2 -> irq_valid_o = 1 in N+3. Latency is 3 cycles.
- irq_id_o, irq_level_o and irq_shv_o are stable while irq_valid_o = 1.
- irq_valid_o and irq_kill_o are never both 1.
- After accept in cycle A: irq_valid_o = 0 in A+1 (ACK). The earliest next offer is A+3.
- Back-to-back register accesses are allowed, one per cycle.

## Configuration
- CVA6_SCLIC_SHV_EN defined: the attr.shv bit is stored, readable, and drives irq_shv_o.
- CVA6_SCLIC_SHV_EN undefined: no shv storage; attr bit 2 reads 0; irq_shv_o is tied to 0.

## Structure
- Shared package (cva6 Sclic package): field-select localparams, attr struct {shv, pol, trig}, FSM state enum.
- One sub-module, sclic_max_tree: combinational, parametrised by NrSrc/LevelW. It returns {found, id, level}, lowest id on ties.

## Test plan
- Source 5 edge, ctl = 0x40, ie = 1, thresh = 0 -> irq_valid_o in N+3 with id 5, level 0x40. Ready -> ip[5] reads 0.
- Sources 3 and 9 both pending, ctl = 0x80 each -> id 3 offered first. After ACK, id 9 is offered at A+3.
- Level source 7, pol = 1, line held 0 -> continuous ip = 1. A write of ip = 0 is ignored and reads back 1.
- Offer id 2 at level 0x30, then thresh_i = 0x30 -> irq_kill_o for one cycle, valid = 0, FSM returns to IDLE.
- Edge on id 4 in the same cycle as its accept -> ip[4] remains 1 and is re-offered.
- rst_ni low while in OFFER -> all outputs 0 immediately, ip/ie read 0 afterward. Run the bench with and without CVA6_SCLIC_SHV_EN and check irq_shv_o.

Source files
------------

// File: rtl/sclic_irq_arbiter_pkg.sv
// sclic_irq_arbiter_pkg: shared field selects, attribute layout and arbiter FSM states.
package sclic_irq_arbiter_pkg;

    localparam logic [1:0] FIELD_IP   = 2'd0;
    localparam logic [1:0] FIELD_IE   = 2'd1;
    localparam logic [1:0] FIELD_ATTR = 2'd2;
    localparam logic [1:0] FIELD_CTL  = 2'd3;

    localparam int unsigned ATTR_TRIG = 0;
    localparam int unsigned ATTR_POL  = 1;
    localparam int unsigned ATTR_SHV  = 2;

    typedef struct packed {
        logic shv;
        logic pol;
        logic trig;
    } attr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_ACK,
        ST_KILL
    } state_e;

    function automatic logic [7:0] attr_byte(attr_t a);
        return {5'b0, a};
    endfunction

endpackage

// File: rtl/sclic_max_tree.sv
// sclic_max_tree: combinational pairwise max reduction over eligible sources.
//   elig_i  : per-source eligibility
//   level_i : per-source level
//   found_o : any source eligible
//   id_o    : winning index (lowest index on equal levels)
//   level_o : winning level
module sclic_max_tree #(
    parameter int unsigned NrSrc  = 64,
    parameter int unsigned LevelW = 8,
    parameter int unsigned SrcW   = $clog2(NrSrc)
) (
    input  logic [NrSrc-1:0]             elig_i,
    input  logic [NrSrc-1:0][LevelW-1:0] level_i,
    output logic                         found_o,
    output logic [SrcW-1:0]              id_o,
    output logic [LevelW-1:0]            level_o
);

    localparam int unsigned P = 1 << SrcW;

    logic [P-1:0]             f;
    logic [P-1:0][SrcW-1:0]   id;
    logic [P-1:0][LevelW-1:0] lv;

    // Node k absorbs node k+span each round; the right side only wins on a
    // strictly greater level, so lower indices win ties.
    always_comb begin
        f  = '0;
        id = '0;
        lv = '0;
        for (int k = 0; k < NrSrc; k++) begin
            f[k]  = elig_i[k];
            id[k] = SrcW'(k);
            lv[k] = level_i[k];
        end
        for (int l = 0; l < SrcW; l++) begin
            for (int k = 0; k < P; k += (2 << l)) begin
                if (f[k + (1 << l)] && (!f[k] || lv[k + (1 << l)] > lv[k])) begin
                    f[k]  = 1'b1;
                    id[k] = id[k + (1 << l)];
                    lv[k] = lv[k + (1 << l)];
                end
            end
        end
    end

    assign found_o = f[0];
    assign id_o    = id[0];
    assign level_o = lv[0];

endmodule

// File: rtl/sclic_irq_arbiter.sv
// sclic_irq_arbiter: CLIC-style per-source interrupt state and highest-level offer to the core.
//   clk_i, rst_ni          : clock, async active-low reset
//   irq_src_i              : raw source lines
//   reg_*                  : register port, addr = {source, field}, field 0 ip / 1 ie / 2 attr / 3 ctl
//   thresh_i               : effective threshold from the core
//   irq_valid_o/ready_i    : offer handshake carrying irq_id_o, irq_level_o, irq_shv_o
//   irq_kill_o             : one-cycle retraction of an offer that lost eligibility
// Build option CVA6_SCLIC_SHV_EN: store attr.shv and drive irq_shv_o; otherwise both read 0.
module sclic_irq_arbiter
    import sclic_irq_arbiter_pkg::*;
#(
    parameter int unsigned NrSrc  = 64,
    parameter int unsigned LevelW = 8,
    parameter int unsigned SrcW   = $clog2(NrSrc)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NrSrc-1:0]  irq_src_i,
    input  logic              reg_req_i,
    input  logic              reg_we_i,
    input  logic [SrcW+1:0]   reg_addr_i,
    input  logic [7:0]        reg_wdata_i,
    output logic [7:0]        reg_rdata_o,
    output logic              reg_rvalid_o,
    input  logic [LevelW-1:0] thresh_i,
    output logic              irq_valid_o,
    output logic [SrcW-1:0]   irq_id_o,
    output logic [LevelW-1:0] irq_level_o,
    output logic              irq_shv_o,
    input  logic              irq_ready_i,
    output logic              irq_kill_o
);

    logic [SrcW-1:0]             reg_idx;
    logic [1:0]                  reg_fld;
    logic [NrSrc-1:0]            ip, ie, pol, trig, act, act_q, elig, wsel, shv_rd;
    logic [NrSrc-1:0][LevelW-1:0] ctl;
    logic                        win_found, win_found_q;
    logic [SrcW-1:0]             win_id, win_id_q, id_q;
    logic [LevelW-1:0]           win_lvl, win_lvl_q, lvl_q;
    logic [7:0]                  rd_val;
    logic                        accept, latch;
    state_e                      state_q, state_d;

    assign {reg_idx, reg_fld} = reg_addr_i;
    assign act    = irq_src_i ^ pol;
    assign accept = (state_q == ST_OFFER) && irq_ready_i;
    assign latch  = (state_q == ST_IDLE) && win_found_q;

    for (genvar k = 0; k < NrSrc; k++) begin : g_src
        assign wsel[k] = reg_req_i && reg_we_i && (reg_idx == SrcW'(k));
        assign elig[k] = ip[k] && ie[k] && (ctl[k] > thresh_i);
    end

    // Level mode mirrors the line; edge mode latches rising edges, and a new
    // edge outranks a same-cycle clear from software or from the accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ip    <= '0;
            ie    <= '0;
            pol   <= '0;
            trig  <= '0;
            ctl   <= '0;
            act_q <= '0;
        end else begin
            act_q <= act;
            for (int k = 0; k < NrSrc; k++) begin
                if (wsel[k] && reg_fld == FIELD_IE)
                    ie[k] <= reg_wdata_i[0];
                if (wsel[k] && reg_fld == FIELD_ATTR) begin
                    pol[k]  <= reg_wdata_i[ATTR_POL];
                    trig[k] <= reg_wdata_i[ATTR_TRIG];
                end
                if (wsel[k] && reg_fld == FIELD_CTL)
                    ctl[k] <= LevelW'(reg_wdata_i);
                if (!trig[k])
                    ip[k] <= act[k];
                else if (act[k] && !act_q[k])
                    ip[k] <= 1'b1;
                else if (wsel[k] && reg_fld == FIELD_IP)
                    ip[k] <= reg_wdata_i[0];
                else if (accept && id_q == SrcW'(k))
                    ip[k] <= 1'b0;
            end
        end
    end

`ifdef CVA6_SCLIC_SHV_EN
    logic [NrSrc-1:0] shv;
    logic             shv_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shv   <= '0;
            shv_q <= 1'b0;
        end else begin
            for (int k = 0; k < NrSrc; k++)
                if (wsel[k] && reg_fld == FIELD_ATTR)
                    shv[k] <= reg_wdata_i[ATTR_SHV];
            if (latch)
                shv_q <= shv[win_id_q];
        end
    end

    assign shv_rd    = shv;
    assign irq_shv_o = shv_q;
`else
    assign shv_rd    = '0;
    assign irq_shv_o = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NrSrc; k++)
            if (reg_idx == SrcW'(k))
                rd_val = reg_fld == FIELD_IP   ? {7'b0, ip[k]} :
                         reg_fld == FIELD_IE   ? {7'b0, ie[k]} :
                         reg_fld == FIELD_ATTR ? attr_byte(attr_t'({shv_rd[k], pol[k], trig[k]})) :
                                                 8'(ctl[k]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_rdata_o  <= '0;
            reg_rvalid_o <= 1'b0;
        end else begin
            reg_rvalid_o <= reg_req_i && !reg_we_i;
            if (reg_req_i && !reg_we_i)
                reg_rdata_o <= rd_val;
        end
    end

    sclic_max_tree #(
        .NrSrc  (NrSrc),
        .LevelW (LevelW),
        .SrcW   (SrcW)
    ) u_max_tree (
        .elig_i  (elig),
        .level_i (ctl),
        .found_o (win_found),
        .id_o    (win_id),
        .level_o (win_lvl)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_found_q <= 1'b0;
            win_id_q    <= '0;
            win_lvl_q   <= '0;
        end else begin
            win_found_q <= win_found;
            win_id_q    <= win_id;
            win_lvl_q   <= win_lvl;
        end
    end

    // Ready outranks a same-cycle loss of eligibility; the ACK cycle gives the
    // ip clear time to reach the winner register before the next offer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = win_found_q ? ST_OFFER : ST_IDLE;
            ST_OFFER: state_d = irq_ready_i ? ST_ACK : (elig[id_q] ? ST_OFFER : ST_KILL);
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            lvl_q   <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                id_q  <= win_id_q;
                lvl_q <= win_lvl_q;
            end
        end
    end

    assign irq_valid_o = state_q == ST_OFFER;
    assign irq_kill_o  = state_q == ST_KILL;
    assign irq_id_o    = id_q;
    assign irq_level_o = lvl_q;

endmodule

// File: tb/tb_sclic_irq_arbiter.sv
// tb_sclic_irq_arbiter: directed register vectors plus multi-cycle offer/accept/kill sequences.
module tb_sclic_irq_arbiter;
    import sclic_irq_arbiter_pkg::*;

    localparam int NrSrc  = 64;
    localparam int LevelW = 8;
    localparam int SrcW   = 6;
`ifdef CVA6_SCLIC_SHV_EN
    localparam logic SHV = 1'b1;
`else
    localparam logic SHV = 1'b0;
`endif

    typedef struct {
        int         idx;
        logic [1:0] fld;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NrSrc-1:0]  irq_src;
    logic              reg_req, reg_we;
    logic [SrcW+1:0]   reg_addr;
    logic [7:0]        reg_wdata, reg_rdata;
    logic              reg_rvalid;
    logic [LevelW-1:0] thresh;
    logic              valid, shv, ready, kill;
    logic [SrcW-1:0]   id;
    logic [LevelW-1:0] level;

    int   total = 0;
    int   bad   = 0;
    vec_t vt[10];

    always #5 clk = ~clk;

    sclic_irq_arbiter #(.NrSrc(NrSrc), .LevelW(LevelW), .SrcW(SrcW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .irq_src_i    (irq_src),
        .reg_req_i    (reg_req),
        .reg_we_i     (reg_we),
        .reg_addr_i   (reg_addr),
        .reg_wdata_i  (reg_wdata),
        .reg_rdata_o  (reg_rdata),
        .reg_rvalid_o (reg_rvalid),
        .thresh_i     (thresh),
        .irq_valid_o  (valid),
        .irq_id_o     (id),
        .irq_level_o  (level),
        .irq_shv_o    (shv),
        .irq_ready_i  (ready),
        .irq_kill_o   (kill)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int idx, input logic [1:0] fld, input logic [7:0] d);
        reg_req   = 1'b1;
        reg_we    = 1'b1;
        reg_addr  = {SrcW'(idx), fld};
        reg_wdata = d;
        step();
        reg_req = 1'b0;
        reg_we  = 1'b0;
    endtask

    task automatic rd(input int idx, input logic [1:0] fld, output logic [7:0] d);
        reg_req  = 1'b1;
        reg_we   = 1'b0;
        reg_addr = {SrcW'(idx), fld};
        step();
        reg_req = 1'b0;
        chk("rvalid", reg_rvalid, 1);
        d = reg_rdata;
    endtask

    task automatic do_reset();
        irq_src = '0;
        ready   = 1'b0;
        reg_req = 1'b0;
        reg_we  = 1'b0;
        thresh  = '0;
        rst_n   = 1'b0;
        step(2);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        logic [7:0] d;
        vt[0] = '{10, FIELD_IE,   8'hFF, 8'h01};
        vt[1] = '{10, FIELD_CTL,  8'hA5, 8'hA5};
        vt[2] = '{11, FIELD_ATTR, 8'h06, SHV ? 8'h06 : 8'h02};
        vt[3] = '{11, FIELD_IP,   8'h00, 8'h01};
        vt[4] = '{12, FIELD_ATTR, 8'h01, 8'h01};
        vt[5] = '{12, FIELD_IP,   8'h00, 8'h00};
        vt[6] = '{63, FIELD_CTL,  8'h7F, 8'h7F};
        vt[7] = '{0,  FIELD_IE,   8'h02, 8'h00};
        vt[8] = '{63, FIELD_ATTR, 8'hF8, 8'h00};
        vt[9] = '{20, FIELD_ATTR, 8'h05, SHV ? 8'h05 : 8'h01};

        irq_src = '0; ready = 1'b0; reg_req = 1'b0; reg_we = 1'b0;
        reg_addr = '0; reg_wdata = '0; thresh = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_valid", valid, 0);
        chk("reset_kill", kill, 0);
        chk("reset_id", id, 0);
        chk("reset_level", level, 0);
        chk("reset_shv", shv, 0);
        chk("reset_rvalid", reg_rvalid, 0);
        chk("reset_rdata", reg_rdata, 0);
        step(2);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            wr(vt[i].idx, vt[i].fld, vt[i].wd);
            rd(vt[i].idx, vt[i].fld, d);
            chk($sformatf("reg_vec%0d", i), d, vt[i].exp);
        end
        chk("vec_no_offer", valid, 0);

        // Single edge source: 3-cycle latency, accept clears ip.
        do_reset();
        wr(5, FIELD_CTL, 8'h40);
        wr(5, FIELD_ATTR, 8'h05);
        wr(5, FIELD_IE, 8'h01);
        irq_src[5] = 1'b1;
        chk("A_n0_valid", valid, 0);
        step();
        chk("A_n1_valid", valid, 0);
        step();
        chk("A_n2_valid", valid, 0);
        step();
        chk("A_n3_valid", valid, 1);
        chk("A_id", id, 5);
        chk("A_level", level, 8'h40);
        chk("A_shv", shv, SHV);
        chk("A_kill", kill, 0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("A_ack_valid", valid, 0);
        rd(5, FIELD_IP, d);
        chk("A_ip_cleared", d, 0);
        chk("A_a2_valid", valid, 0);
        step();
        chk("A_a3_valid", valid, 0);

        // Equal levels: lowest index first, the other re-offered at A+3.
        do_reset();
        wr(3, FIELD_CTL, 8'h80);
        wr(9, FIELD_CTL, 8'h80);
        wr(3, FIELD_ATTR, 8'h01);
        wr(9, FIELD_ATTR, 8'h01);
        wr(3, FIELD_IE, 8'h01);
        wr(9, FIELD_IE, 8'h01);
        irq_src[3] = 1'b1;
        irq_src[9] = 1'b1;
        step(3);
        chk("B_valid", valid, 1);
        chk("B_id_first", id, 3);
        chk("B_level", level, 8'h80);
        chk("B_shv", shv, 0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("B_a1_valid", valid, 0);
        step();
        chk("B_a2_valid", valid, 0);
        step();
        chk("B_a3_valid", valid, 1);
        chk("B_id_second", id, 9);

        // Level source with inverted polarity ignores software ip writes.
        do_reset();
        wr(7, FIELD_ATTR, 8'h02);
        step();
        rd(7, FIELD_IP, d);
        chk("C_ip_level", d, 1);
        wr(7, FIELD_IP, 8'h00);
        rd(7, FIELD_IP, d);
        chk("C_ip_write_ignored", d, 1);
        step(3);
        rd(7, FIELD_IP, d);
        chk("C_ip_held", d, 1);
        chk("C_no_offer", valid, 0);

        // Offer held against a higher arrival, then killed by threshold.
        do_reset();
        wr(2, FIELD_CTL, 8'h30);
        wr(2, FIELD_ATTR, 8'h01);
        wr(2, FIELD_IE, 8'h01);
        wr(6, FIELD_CTL, 8'h90);
        wr(6, FIELD_ATTR, 8'h01);
        wr(6, FIELD_IE, 8'h01);
        irq_src[2] = 1'b1;
        step(3);
        chk("D_valid", valid, 1);
        chk("D_id", id, 2);
        chk("D_level", level, 8'h30);
        irq_src[6] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("D_hold_valid", valid, 1);
            chk("D_hold_id", id, 2);
            chk("D_hold_level", level, 8'h30);
        end
        thresh = 8'h30;
        chk("D_k0_valid", valid, 1);
        step();
        chk("D_kill", kill, 1);
        chk("D_kill_valid", valid, 0);
        step();
        chk("D_kill_pulse", kill, 0);
        chk("D_idle_valid", valid, 0);
        step();
        chk("D_reoffer_valid", valid, 1);
        chk("D_reoffer_id", id, 6);
        chk("D_reoffer_level", level, 8'h90);
        chk("D_reoffer_kill", kill, 0);

        // Edge coinciding with accept keeps ip set and re-offers.
        do_reset();
        wr(4, FIELD_CTL, 8'h20);
        wr(4, FIELD_ATTR, 8'h01);
        wr(4, FIELD_IE, 8'h01);
        irq_src[4] = 1'b1;
        step();
        irq_src[4] = 1'b0;
        step(2);
        chk("E_valid", valid, 1);
        chk("E_id", id, 4);
        irq_src[4] = 1'b1;
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("E_ack_valid", valid, 0);
        rd(4, FIELD_IP, d);
        chk("E_ip_kept", d, 1);
        chk("E_a2_valid", valid, 0);
        step();
        chk("E_reoffer_valid", valid, 1);
        chk("E_reoffer_id", id, 4);

        // Asynchronous reset while offering.
        rst_n = 1'b0;
        #1;
        chk("F_valid", valid, 0);
        chk("F_kill", kill, 0);
        chk("F_id", id, 0);
        chk("F_level", level, 0);
        chk("F_shv", shv, 0);
        irq_src = '0;
        @(posedge clk);
        #1;
        chk("F_kill_in_reset", kill, 0);
        rst_n = 1'b1;
        step();
        rd(4, FIELD_IP, d);
        chk("F_ip", d, 0);
        rd(4, FIELD_IE, d);
        chk("F_ie", d, 0);
        rd(4, FIELD_CTL, d);
        chk("F_ctl", d, 0);
        chk("F_after_valid", valid, 0);
        chk("F_after_kill", kill, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
